ps2_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_clk_filter.sv | 42 ++++
 rtl/ps2_rx.sv | 127 ++++++++++++
 tb/tb_ps2_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver state encodings, parity helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ps2_pkg;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;   // start + 8 data + parity + stop

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_DPS_ENC  = 2'd1;
    localparam logic [1:0] ST_LOAD_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_DPS  = ST_DPS_ENC,
        ST_LOAD = ST_LOAD_ENC
    } rx_state_e;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter for the raw PS/2 clock plus falling-edge detector.
// Latency: f_ps2c follows ps2c after FILTER_LEN stable samples; fall_edge is combinational on that change.
// Backpressure: none, free-running.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic f_ps2c,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filter_q, filter_d;
    logic                  f_ps2c_q, f_ps2c_d;

    // Shift history and filtered level; the history also acts as the pad synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_q <= '0;
            f_ps2c_q <= 1'b0;
        end else begin
            filter_q <= filter_d;
            f_ps2c_q <= f_ps2c_d;
        end
    end

    // Filtered level flips only once the whole history agrees, otherwise it holds.
    always_comb begin
        filter_d = {ps2c, filter_q[FILTER_LEN-1:1]};
        f_ps2c_d = f_ps2c_q;
        if (filter_q == {FILTER_LEN{1'b1}}) begin
            f_ps2c_d = 1'b1;
        end else if (filter_q == {FILTER_LEN{1'b0}}) begin
            f_ps2c_d = 1'b0;
        end
    end

    assign f_ps2c    = f_ps2c_q;
    assign fall_edge = f_ps2c_q & ~f_ps2c_d;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: start, 8 data LSB first, odd parity, stop; flags parity/stop errors and stalls.
// Latency: rx_done_tick 1 cycle after the stop bit's filtered falling edge; dout valid the cycle after.
// Backpressure: none; rx_en low ignores the line and aborts any frame in progress.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000,
    parameter int TO_W       = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2c,
    input  logic                     ps2d,
    input  logic                     rx_en,
    output logic                     rx_idle,
    output logic                     rx_done_tick,
    output logic [PS2_DATA_BITS-1:0] dout,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     timeout_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    rx_state_e                 state_q, state_d;
    logic [PS2_FRAME_BITS-2:0] b_q, b_d;      // {stop, parity, d7..d0} after a full frame
    logic [3:0]                n_q, n_d;
    logic [TO_W-1:0]           timer_q, timer_d;
    logic [PS2_DATA_BITS-1:0]  dout_q, dout_d;
    logic                      ps2d_meta_q, ps2d_s_q;
    logic                      fall_edge;
    logic                      f_ps2c_unused;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .f_ps2c    (f_ps2c_unused),
        .fall_edge (fall_edge)
    );

    // Two-flop synchronizer for the data pad.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2d_meta_q <= 1'b1;
            ps2d_s_q    <= 1'b1;
        end else begin
            ps2d_meta_q <= ps2d;
            ps2d_s_q    <= ps2d_meta_q;
        end
    end

    // Receiver state, shift register, bit counter, stall timer and output byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            b_q     <= '0;
            n_q     <= '0;
            timer_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            n_q     <= n_d;
            timer_q <= timer_d;
            dout_q  <= dout_d;
        end
    end

    // Frame sequencing: rx_en abort beats everything, an edge beats the stall timeout.
    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        n_d          = n_q;
        timer_d      = timer_q;
        dout_d       = dout_q;
        rx_idle      = 1'b0;
        rx_done_tick = 1'b0;
        parity_err   = 1'b0;
        frame_err    = 1'b0;
        timeout_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rx_idle = 1'b1;
                if (fall_edge && rx_en && !ps2d_s_q) begin
                    n_d     = 4'd9;
                    timer_d = '0;
                    state_d = ST_DPS;
                end
            end
            ST_DPS: begin
                if (!rx_en) begin
                    state_d = ST_IDLE;
                end else if (fall_edge) begin
                    b_d     = {ps2d_s_q, b_q[PS2_FRAME_BITS-2:1]};
                    timer_d = '0;
                    if (n_q == 4'd0) begin
                        state_d = ST_LOAD;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end else if (timer_q == TO_LAST) begin
                    timeout_err = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOAD: begin
                dout_d       = b_q[PS2_DATA_BITS-1:0];
                rx_done_tick = 1'b1;
                parity_err   = (b_q[PS2_DATA_BITS] != odd_parity(b_q[PS2_DATA_BITS-1:0]));
                frame_err    = ~b_q[PS2_FRAME_BITS-2];
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames, error cases, stall timeout, rx_en abort, glitch, reset, random frames.
// Latency: expectations derived from pad-edge times (filter depth + 1 for done, filter depth + TIMEOUT for timeout).
// Backpressure: n/a.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int TO_W       = 18;

    logic       clk;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rx_idle;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    int   cyc = 0;
    int   fall_cyc = 0;          // cycle in which the most recent pad falling edge was driven
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   stray_cnt = 0;
    int   idle_bad = 0;
    int   last_done_cyc = 0;
    int   last_to_cyc = 0;
    logic last_pe = 1'b0;
    logic last_fe = 1'b0;
    logic chk_idle_next = 1'b0;
    logic busy_seen = 1'b0;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .TO_W       (TO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .rx_idle      (rx_idle),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_pe = parity_err;
            last_fe = frame_err;
            if (rx_idle) idle_bad++;
            chk_idle_next = 1'b1;
        end else if (chk_idle_next) begin
            if (!rx_idle) idle_bad++;
            chk_idle_next = 1'b0;
        end
        if (!rx_done_tick && (parity_err || frame_err)) stray_cnt++;
        if (timeout_err) begin
            to_cnt++;
            last_to_cyc = cyc;
        end
        if (!rx_idle) busy_seen = 1'b1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive bits LSB first, 400-cycle clock period, data changing mid-high.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int drop_at);
        for (int i = 0; i < nbits; i++) begin
            ps2c = 1'b1;
            wait_cyc(100);
            ps2d = bits[i];
            wait_cyc(100);
            if (i == drop_at) rx_en = 1'b0;
            ps2c = 1'b0;
            fall_cyc = cyc;
            wait_cyc(200);
        end
        ps2c = 1'b1;
        wait_cyc(100);
        ps2d = 1'b1;
        wait_cyc(100);
    endtask

    // Full frame against the reference model: odd parity over data+parity, stop must be 1.
    task automatic run_frame(input logic [7:0] data, input logic par, input logic stop);
        int   d0 = done_cnt;
        int   t0 = to_cnt;
        logic exp_pe = (($countones({par, data}) % 2) == 0);
        logic exp_fe = (stop == 1'b0);
        logic [10:0] bits = {stop, par, data, 1'b0};
        send_bits(bits, 11, -1);
        wait_cyc(20);
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL frame_done_count data=%02h got=%0d want=1", data, done_cnt - d0);
        end
        vectors++;
        if (last_pe !== exp_pe) begin
            miscompares++;
            $display("FAIL parity_err data=%02h par=%0b got=%0b want=%0b", data, par, last_pe, exp_pe);
        end
        vectors++;
        if (last_fe !== exp_fe) begin
            miscompares++;
            $display("FAIL frame_err data=%02h stop=%0b got=%0b want=%0b", data, stop, last_fe, exp_fe);
        end
        vectors++;
        if (dout !== data) begin
            miscompares++;
            $display("FAIL dout got=%02h want=%02h", dout, data);
        end
        // Stop-bit fall_edge is seen FILTER_LEN cycles after the pad edge; done follows one cycle later.
        vectors++;
        if (last_done_cyc !== fall_cyc + FILTER_LEN + 1) begin
            miscompares++;
            $display("FAIL done_latency got=%0d want=%0d", last_done_cyc - fall_cyc, FILTER_LEN + 1);
        end
        vectors++;
        if (to_cnt !== t0) begin
            miscompares++;
            $display("FAIL frame_spurious_timeout got=%0d want=%0d", to_cnt, t0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(5);
        vectors++;
        if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL reset_rx_idle got=%0b want=1", rx_idle); end
        vectors++;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%02h want=00", dout); end
        vectors++;
        if ({rx_done_tick, parity_err, frame_err, timeout_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ticks got=%04b want=0000", {rx_done_tick, parity_err, frame_err, timeout_err});
        end
        reset = 1'b0;
        wait_cyc(30);
    endtask

    task automatic test_good_frame();
        run_frame(8'hFA, 1'b1, 1'b1);
    endtask

    task automatic test_parity_err();
        run_frame(8'h08, 1'b1, 1'b1);
    endtask

    task automatic test_frame_err();
        run_frame(8'h55, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int t0 = to_cnt;
        logic [7:0]  dprev = dout;
        logic [10:0] bits = {1'b1, 1'b1, 8'hAA, 1'b0};
        send_bits(bits, 5, -1);
        wait_cyc(TIMEOUT + 100);
        vectors++;
        if (to_cnt - t0 !== 1) begin miscompares++; $display("FAIL timeout_count got=%0d want=1", to_cnt - t0); end
        // Last fall_edge lands FILTER_LEN cycles after the pad edge; timeout follows TIMEOUT cycles later.
        vectors++;
        if (last_to_cyc !== fall_cyc + FILTER_LEN + TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_latency got=%0d want=%0d", last_to_cyc - fall_cyc, FILTER_LEN + TIMEOUT);
        end
        vectors++;
        if (done_cnt !== d0) begin miscompares++; $display("FAIL timeout_no_done got=%0d want=%0d", done_cnt, d0); end
        vectors++;
        if (dout !== dprev) begin miscompares++; $display("FAIL timeout_dout got=%02h want=%02h", dout, dprev); end
        run_frame(8'hAA, 1'b1, 1'b1);
    endtask

    task automatic test_rx_en();
        int d0 = done_cnt;
        int t0 = to_cnt;
        logic [10:0] bits = {1'b1, 1'b1, 8'h12, 1'b0};
        rx_en = 1'b0;
        busy_seen = 1'b0;
        send_bits(bits, 11, -1);
        vectors++;
        if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL rx_en_low_idle got_busy=%0b want=0", busy_seen); end
        rx_en = 1'b1;
        wait_cyc(20);
        busy_seen = 1'b0;
        bits = {1'b1, 1'b0, 8'h34, 1'b0};
        send_bits(bits, 11, 3);
        wait_cyc(TIMEOUT + 50);
        vectors++;
        if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL rx_en_drop_started got=%0b want=1", busy_seen); end
        vectors++;
        if (done_cnt !== d0) begin miscompares++; $display("FAIL rx_en_no_done got=%0d want=%0d", done_cnt, d0); end
        vectors++;
        if (to_cnt !== t0) begin miscompares++; $display("FAIL rx_en_no_timeout got=%0d want=%0d", to_cnt, t0); end
        vectors++;
        if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL rx_en_abort_idle got=%0b want=1", rx_idle); end
        rx_en = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        ps2d = 1'b0;
        wait_cyc(10);
        busy_seen = 1'b0;
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(50);
        vectors++;
        if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL glitch_state got_busy=%0b want=0", busy_seen); end
        vectors++;
        if (done_cnt !== d0) begin miscompares++; $display("FAIL glitch_done got=%0d want=%0d", done_cnt, d0); end
        ps2d = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_reset_mid_frame();
        int d0 = done_cnt;
        int t0 = to_cnt;
        logic [10:0] bits = {1'b1, 1'b1, 8'h3C, 1'b0};
        send_bits(bits, 5, -1);
        vectors++;
        if (rx_idle !== 1'b0) begin miscompares++; $display("FAIL midframe_busy got=%0b want=0", rx_idle); end
        reset = 1'b1;
        wait_cyc(1);
        vectors++;
        if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL midreset_rx_idle got=%0b want=1", rx_idle); end
        vectors++;
        if (dout !== 8'h00) begin miscompares++; $display("FAIL midreset_dout got=%02h want=00", dout); end
        reset = 1'b0;
        wait_cyc(TIMEOUT + 50);
        vectors++;
        if ((done_cnt - d0) + (to_cnt - t0) !== 0) begin
            miscompares++;
            $display("FAIL midreset_ticks got=%0d want=0", (done_cnt - d0) + (to_cnt - t0));
        end
        run_frame(8'h3C, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            logic [7:0] data = 8'($urandom);
            logic       par  = (~(^data)) ^ ($urandom_range(0, 3) == 0);
            logic       stop = ($urandom_range(0, 3) != 0);
            run_frame(data, par, stop);
        end
    endtask

    task automatic test_flag_hygiene();
        vectors++;
        if (stray_cnt !== 0) begin miscompares++; $display("FAIL stray_err_flags got=%0d want=0", stray_cnt); end
        vectors++;
        if (idle_bad !== 0) begin miscompares++; $display("FAIL idle_around_done got=%0d want=0", idle_bad); end
    endtask

    initial begin
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_timeout();
        test_rx_en();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        test_flag_hygiene();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
